// File: rtl/greenrisc_core.sv
// GreenRISC second-generation core: two-state FETCH/EXEC RV32I subset (branches, ADDI, ADD, SUB)
// with a byte-serial flash port into little-endian instruction memory and a debug register read port.
module greenrisc_core #(
    parameter int          IMEM_ADDR_W = 14,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flash,
    input  logic [7:0]             data,
    input  logic [IMEM_ADDR_W-1:0] addr,
    input  logic [4:0]             dbg_raddr,
    output logic [31:0]            dbg_rdata,
    output logic [31:0]            pc_out,
    output logic                   halted
);

    localparam int         DEPTH     = 1 << (IMEM_ADDR_W - 2);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {FETCH, EXEC} state_t;

    state_t             state_q, state_d;
    logic        [31:0] pc_q, pc_d;
    logic        [31:0] instr_q;
    logic               halted_q, halted_d;
    logic        [31:0] imem [DEPTH];
    logic        [31:0] rf_q [32];

    logic               rf_we;
    logic        [31:0] rf_wdata;
    logic               illegal;

    logic        [6:0]  opcode;
    logic        [2:0]  funct3;
    logic        [6:0]  funct7;
    logic        [4:0]  rs1, rs2, rd;
    logic signed [31:0] rs1_val, rs2_val, imm_i, imm_b;
    logic        [31:0] br_target;

    function automatic logic br_taken(input logic [2:0] f3,
                                      input logic signed [31:0] a,
                                      input logic signed [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return a < b;
            3'b101:  return a >= b;
            3'b110:  return $unsigned(a) < $unsigned(b);
            3'b111:  return $unsigned(a) >= $unsigned(b);
            default: return 1'b0;
        endcase
    endfunction

    assign opcode    = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7    = instr_q[31:25];
    assign rd        = instr_q[11:7];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign rs1_val   = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val   = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    assign imm_i     = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_b     = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign br_target = pc_q + imm_b;

    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf_q[dbg_raddr];
    assign pc_out    = pc_q;
    assign halted    = halted_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        illegal  = 1'b0;
        case (state_q)
            FETCH: if (!halted_q) state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + 32'd4;
                case (opcode)
                    OP_IMM: begin
                        if (funct3 == 3'b000) begin
                            rf_we    = 1'b1;
                            rf_wdata = rs1_val + imm_i;
                        end else illegal = 1'b1;
                    end
                    OP_REG: begin
                        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                            rf_we    = 1'b1;
                            rf_wdata = rs1_val + rs2_val;
                        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                            rf_we    = 1'b1;
                            rf_wdata = rs1_val - rs2_val;
                        end else illegal = 1'b1;
                    end
                    OP_BRANCH: begin
                        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
                        else if (br_taken(funct3, rs1_val, rs2_val)) begin
                            // Targets must stay word aligned; bit 1 set is a fault.
                            if (br_target[1]) illegal = 1'b1;
                            else              pc_d    = br_target;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                    rf_we    = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            instr_q  <= '0;
        end else if (flash) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            if (state_q == FETCH && !halted_q)
                instr_q <= imem[pc_q[IMEM_ADDR_W-1:2]];
        end
    end

    // Reset or flash on the retire edge aborts the write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (!flash && rf_we && rd != 5'd0) begin
            rf_q[rd] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (flash)
            imem[addr[IMEM_ADDR_W-1:2]][{addr[1:0], 3'b000} +: 8] <= data;
    end

endmodule

// File: tb/tb_greenrisc_core.sv
// Bench for greenrisc_core: flashes programs, runs the core and compares its registers, PC
// and halt flag with an instruction-level model of the GreenRISC subset.
`timescale 1ns/1ps
module tb_greenrisc_core;

    localparam int          AW     = 8;
    localparam int          DEPTH  = 1 << (AW - 2);
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          flash;
    logic [7:0]    data;
    logic [AW-1:0] addr;
    logic [4:0]    dbg_raddr;
    logic [31:0]   dbg_rdata;
    logic [31:0]   pc_out;
    logic          halted;

    greenrisc_core #(.IMEM_ADDR_W(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .flash(flash), .data(data), .addr(addr),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_pc;
    logic        m_halt;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] prog [$];

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        logic [11:0] i12;
        logic [4:0]  r1, d;
        i12 = imm[11:0]; r1 = rs1[4:0]; d = rd[4:0];
        return {i12, r1, 3'b000, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input bit sub, input int rd, input int rs1, input int rs2);
        logic [4:0] r1, r2, d;
        r1 = rs1[4:0]; r2 = rs2[4:0]; d = rd[4:0];
        return {(sub ? 7'b0100000 : 7'b0000000), r2, r1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        logic [12:0] i13;
        logic [4:0]  r1, r2;
        i13 = imm[12:0]; r1 = rs1[4:0]; r2 = rs2[4:0];
        return {i13[12], i13[10:5], r2, r1, f3, i13[4:1], i13[11], 7'b1100011};
    endfunction

    // One architectural instruction, straight from the ISA rules.
    function automatic void iss_step();
        logic [31:0] ins, a, b, nxt, target, res;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        take, bad, wr;
        if (m_halt) return;
        ins = m_mem[m_pc[AW-1:2]];
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
        a = m_rf[ins[19:15]]; b = m_rf[ins[24:20]];
        nxt = m_pc + 32'd4; bad = 1'b0; take = 1'b0; wr = 1'b0; res = '0;
        if (op == 7'h13 && f3 == 3'd0) begin
            wr = 1'b1; res = a + {{20{ins[31]}}, ins[31:20]};
        end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
            wr = 1'b1; res = a + b;
        end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
            wr = 1'b1; res = a - b;
        end else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            case (f3)
                3'd0:    take = (a == b);
                3'd1:    take = (a != b);
                3'd4:    take = ($signed(a) < $signed(b));
                3'd5:    take = ($signed(a) >= $signed(b));
                3'd6:    take = (a < b);
                default: take = (a >= b);
            endcase
            if (take) begin
                target = m_pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                if (target[1]) bad = 1'b1;
                else           nxt = target;
            end
        end else begin
            bad = 1'b1;
        end
        if (bad) m_halt = 1'b1;
        else begin
            m_pc = nxt;
            if (wr && rd != 5'd0) m_rf[rd] = res;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_pc = '0;
        m_halt = 1'b0;
    endfunction

    task automatic run(input int ncyc);
        repeat (ncyc) @(negedge clk);
        for (int k = 0; k < ncyc / 2; k++) iss_step();
    endtask

    task automatic flash_words(input int base);
        logic [31:0] wd;
        @(negedge clk);
        flash = 1'b1;
        reset = 1'b0;
        for (int w = 0; w < prog.size(); w++) begin
            wd = prog[w];
            for (int b = 0; b < 4; b++) begin
                addr = AW'((base + w) * 4 + b);
                data = wd[8*b +: 8];
                @(negedge clk);
            end
            m_mem[base + w] = wd;
        end
    endtask

    task automatic release_flash();
        flash  = 1'b0;
        m_pc   = '0;
        m_halt = 1'b0;
    endtask

    task automatic get_reg(input int i, output logic [31:0] v);
        dbg_raddr = i[4:0];
        #1;
        v = dbg_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; flash = 1'b0; data = '0; addr = '0; dbg_raddr = '0;
        repeat (3) @(negedge clk);
        model_reset();
        n_total++;
        if (pc_out !== 32'h0) $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); else n_pass++;
        n_total++;
        if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            get_reg(i, v);
            n_total++;
            if (v !== 32'h0) $display("FAIL reset_x%0d got %h want 0", i, v); else n_pass++;
        end
    endtask

    task automatic test_first_instr();
        prog.delete();
        prog.push_back(enc_addi(1, 0, 5));
        prog.push_back(HALT_W);
        flash_words(0);
        release_flash();
        dbg_raddr = 5'd1;
        @(negedge clk);
        n_total++;
        if (pc_out !== 32'h0 || dbg_rdata !== 32'h0)
            $display("FAIL first_edge1 pc %h x1 %h want pc 0 x1 0", pc_out, dbg_rdata); else n_pass++;
        @(negedge clk);
        iss_step();
        n_total++;
        if (dbg_rdata !== 32'd5) $display("FAIL first_x1 got %h want 5", dbg_rdata); else n_pass++;
        n_total++;
        if (pc_out !== 32'd4 || halted !== 1'b0)
            $display("FAIL first_pc got %h/%b want 4/0", pc_out, halted); else n_pass++;
    endtask

    task automatic test_alu_fixed();
        logic [31:0] v;
        logic [31:0] want [5];
        want = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h2};
        prog.delete();
        prog.push_back(enc_addi(1, 0, -1));
        prog.push_back(enc_addi(2, 0, 1));
        prog.push_back(enc_r(1'b0, 3, 1, 2));
        prog.push_back(enc_r(1'b1, 4, 2, 1));
        prog.push_back(enc_addi(0, 0, 7));
        prog.push_back(HALT_W);
        flash_words(0);
        release_flash();
        run(8);
        for (int i = 1; i < 5; i++) begin
            get_reg(i, v);
            n_total++;
            if (v !== want[i]) $display("FAIL alu_x%0d got %h want %h", i, v, want[i]); else n_pass++;
        end
        run(4);
        get_reg(0, v);
        n_total++;
        if (v !== 32'h0) $display("FAIL alu_x0 got %h want 0", v); else n_pass++;
        n_total++;
        if (pc_out !== 32'd20 || halted !== 1'b1)
            $display("FAIL alu_halt pc %h halted %b want 14/1", pc_out, halted); else n_pass++;
    endtask

    task automatic test_alu_random();
        logic [31:0] v;
        for (int it = 0; it < 4; it++) begin
            prog.delete();
            for (int n = 0; n < 12; n++) begin
                case ($urandom_range(0, 2))
                    0:       prog.push_back(enc_addi($urandom_range(0, 7), $urandom_range(0, 7),
                                                     int'($urandom_range(0, 4095))));
                    1:       prog.push_back(enc_r(1'b0, $urandom_range(0, 7), $urandom_range(0, 7),
                                                  $urandom_range(0, 7)));
                    default: prog.push_back(enc_r(1'b1, $urandom_range(0, 7), $urandom_range(0, 7),
                                                  $urandom_range(0, 7)));
                endcase
            end
            prog.push_back(HALT_W);
            flash_words(0);
            release_flash();
            run(30);
            for (int i = 0; i < 8; i++) begin
                get_reg(i, v);
                n_total++;
                if (v !== m_rf[i]) $display("FAIL rand%0d_x%0d got %h want %h", it, i, v, m_rf[i]); else n_pass++;
            end
            n_total++;
            if (pc_out !== m_pc || halted !== m_halt)
                $display("FAIL rand%0d_pc got %h/%b want %h/%b", it, pc_out, halted, m_pc, m_halt); else n_pass++;
        end
    endtask

    task automatic test_branches();
        logic [2:0]  f3s [6];
        logic [31:0] pc_fixed [6];
        int a, b;
        f3s      = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        pc_fixed = '{32'd12, 32'd16, 32'd16, 32'd12, 32'd12, 32'd16};
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 4; p++) begin
                a = int'($urandom_range(0, 4095)) - 2048;
                b = (p == 1) ? a : int'($urandom_range(0, 4095)) - 2048;
                if (p == 0) begin a = -1; b = 1; end
                prog.delete();
                prog.push_back(enc_addi(1, 0, a));
                prog.push_back(enc_addi(2, 0, b));
                prog.push_back(enc_b(f3s[f], 1, 2, 8));
                prog.push_back(HALT_W);
                prog.push_back(HALT_W);
                flash_words(0);
                release_flash();
                run(10);
                n_total++;
                if (pc_out !== m_pc || halted !== m_halt)
                    $display("FAIL br_f%0d_p%0d got %h/%b want %h/%b", f3s[f], p, pc_out, halted, m_pc, m_halt);
                else n_pass++;
                if (p == 0) begin
                    n_total++;
                    if (pc_out !== pc_fixed[f])
                        $display("FAIL br_m1_vs_1_f%0d got %h want %h", f3s[f], pc_out, pc_fixed[f]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        prog.delete();
        prog.push_back(HALT_W);
        flash_words(0);
        release_flash();
        @(negedge clk);
        n_total++;
        if (halted !== 1'b0) $display("FAIL ill_edge1 got %b want 0", halted); else n_pass++;
        @(negedge clk);
        iss_step();
        n_total++;
        if (halted !== 1'b1 || pc_out !== 32'h0)
            $display("FAIL ill_edge2 got %b/%h want 1/0", halted, pc_out); else n_pass++;
        run(20);
        n_total++;
        if (halted !== 1'b1 || pc_out !== 32'h0)
            $display("FAIL ill_sticky got %b/%h want 1/0", halted, pc_out); else n_pass++;
        for (int i = 1; i < 8; i++) begin
            get_reg(i, v);
            n_total++;
            if (v !== m_rf[i]) $display("FAIL ill_x%0d got %h want %h", i, v, m_rf[i]); else n_pass++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_total++;
        if (halted !== 1'b0 || pc_out !== 32'h0)
            $display("FAIL ill_reset got %b/%h want 0/0", halted, pc_out); else n_pass++;
        run(4);
        n_total++;
        if (halted !== m_halt) $display("FAIL ill_rehalt got %b want %b", halted, m_halt); else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] v;
        prog.delete();
        prog.push_back(enc_addi(3, 0, 33));
        prog.push_back(enc_b(3'd0, 0, 0, 6));
        prog.push_back(HALT_W);
        prog.push_back(HALT_W);
        flash_words(0);
        release_flash();
        run(8);
        get_reg(3, v);
        n_total++;
        if (v !== 32'd33) $display("FAIL mis_x3 got %h want 21", v); else n_pass++;
        n_total++;
        if (pc_out !== 32'd4 || halted !== 1'b1 || pc_out !== m_pc)
            $display("FAIL mis_halt got %h/%b want 4/1", pc_out, halted); else n_pass++;
    endtask

    task automatic test_alias();
        prog.delete();
        prog.push_back(enc_addi(7, 0, 123));
        flash_words(DEPTH - 1);
        prog.delete();
        prog.push_back(enc_b(3'd0, 0, 0, -4));
        flash_words(0);
        release_flash();
        dbg_raddr = 5'd7;
        run(2);
        n_total++;
        if (pc_out !== 32'hFFFF_FFFC || pc_out !== m_pc)
            $display("FAIL alias_pc got %h want fffffffc", pc_out); else n_pass++;
        run(2);
        n_total++;
        if (dbg_rdata !== 32'd123 || dbg_rdata !== m_rf[7])
            $display("FAIL alias_x7 got %h want 7b", dbg_rdata); else n_pass++;
        n_total++;
        if (pc_out !== 32'h0) $display("FAIL alias_wrap got %h want 0", pc_out); else n_pass++;
    endtask

    task automatic test_flash_abort();
        logic [31:0] w;
        logic [31:0] v;
        w = enc_addi(5, 0, 77);
        prog.delete();
        prog.push_back(w);
        prog.push_back(HALT_W);
        flash_words(0);
        release_flash();
        @(negedge clk);
        flash = 1'b1; addr = '0; data = w[7:0];
        @(negedge clk);
        release_flash();
        flash = 1'b1;
        get_reg(5, v);
        n_total++;
        if (v !== m_rf[5] || pc_out !== 32'h0)
            $display("FAIL abort_x5 got %h pc %h want %h pc 0", v, pc_out, m_rf[5]); else n_pass++;
        @(negedge clk);
        release_flash();
        dbg_raddr = 5'd5;
        run(2);
        n_total++;
        if (dbg_rdata !== 32'd77) $display("FAIL abort_rerun got %h want 4d", dbg_rdata); else n_pass++;
    endtask

    task automatic test_reset_flash();
        logic [31:0] v;
        @(negedge clk);
        reset = 1'b1; flash = 1'b1; addr = '0; data = m_mem[0][7:0];
        @(negedge clk);
        model_reset();
        n_total++;
        if (pc_out !== 32'h0 || halted !== 1'b0)
            $display("FAIL rf_both_pc got %h/%b want 0/0", pc_out, halted); else n_pass++;
        for (int i = 1; i < 8; i++) begin
            get_reg(i, v);
            n_total++;
            if (v !== 32'h0) $display("FAIL rf_both_x%0d got %h want 0", i, v); else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
        release_flash();
        dbg_raddr = 5'd5;
        run(4);
        n_total++;
        if (dbg_rdata !== 32'd77 || halted !== m_halt)
            $display("FAIL rf_both_run got %h/%b want 4d/%b", dbg_rdata, halted, m_halt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_instr();
        test_alu_fixed();
        test_alu_random();
        test_branches();
        test_illegal();
        test_misaligned();
        test_alias();
        test_flash_abort();
        test_reset_flash();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/greenrisc_core.md
# greenrisc_core

Parametrised second-generation GreenRISC core: a two-state (FETCH/EXEC) RV32I-subset processor with byte-writable instruction memory, a 32-entry register file and full execution of integer branches, ADDI, ADD and SUB. A byte-serial flash port loads the program while the core is held idle. The core is the top-level compute block and replaces the fetch-and-decode-only top. It exposes the PC, a halt flag and a debug register-read port for bring-up and verification.

## Interface
- IMEM_ADDR_W, 14: instruction memory byte-address width; depth is 2^(IMEM_ADDR_W-2) 32-bit words.
- RESET_PC, 32'h0000_0000: PC value after reset and after flash mode ends; must be 4-byte aligned.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flash  in  1  level; high = program-load mode, core execution frozen.
- data  in  8  flash byte to write.
- addr  in  IMEM_ADDR_W  flash byte address.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  32  combinational read of x[dbg_raddr]; 0 when dbg_raddr==0.
- pc_out  out  32  current PC register.
- halted  out  1  sticky; set on illegal or misaligned-branch instruction.

## Operation
- Imem is little-endian and byte-writable. While flash=1, every cycle writes data to byte lane addr[1:0] of word addr[IMEM_ADDR_W-1:2]. Imem contents are not cleared by reset.
- FSM states: FETCH, EXEC. Reset → FETCH.
  - FETCH: synchronous imem read at pc[IMEM_ADDR_W-1:2] latched into instr register → EXEC.
  - EXEC: decode instr; update regfile/PC → FETCH.
  - Each instruction takes exactly 2 cycles.
- flash=1 (reset=0): state forced to FETCH, pc ← RESET_PC, halted ← 0, regfile unchanged, no execution. Execution resumes with FETCH on the first cycle flash=0.
- Supported decode, on opcode, funct3 and funct7[5]:
  - BEQ, BNE, BLT, BGE (signed); BLTU, BGEU (unsigned).
  - ADDI (funct3 000, opcode 0010011).
  - ADD (funct7 0000000, funct3 000, opcode 0110011); SUB (funct7 0100000, same funct3/opcode).
- Arithmetic is 32-bit modulo 2^32; overflow ignored.
- ADDI immediate: sign-extended instr[31:20].
- Branch immediate: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- Taken branch: pc ← pc + imm. Not-taken branch and ALU ops: pc ← pc + 4. 32-bit wrap.
- Imem index uses pc[IMEM_ADDR_W-1:2] only; upper PC bits alias.
- x0 reads 0; writes to rd=0 are discarded.
- Any other encoding → halted ← 1, no regfile write, pc unchanged.
- A taken-branch target with bit 1 set → halted ← 1, pc unchanged.
- While halted=1: FSM idles in FETCH, no state changes. Cleared only by reset or flash.

## Timing
- reset=1 has priority over flash. Next edge: pc_out=RESET_PC, halted=0, state=FETCH, instr=0, all x1..x31=0.
- Regfile write and PC update occur on the EXEC→FETCH edge. Result is visible on dbg_rdata in the following cycle (combinational read of the registered regfile).
- EXEC reads rs1/rs2 combinationally. A back-to-back dependency therefore needs no forwarding.
- Flash write latency: a byte written at edge N is fetchable by a FETCH at edge N+1 or later.
- Reset or flash asserted mid-EXEC aborts the instruction: no regfile write, pc ← RESET_PC.
- First instruction after reset or flash deassert: fetched at edge 1, retired at edge 2.

## Test plan
- Flash bytes 93,00,50,00 at addr 0..3 (ADDI x1,x0,5), drop flash, run 2 cycles → x1=5, pc_out=4, halted=0.
- Program ADDI x1,x0,-1; ADDI x2,x0,1; ADD x3,x1,x2; SUB x4,x2,x1 → x1=FFFFFFFF, x3=0 (wrap), x4=2 after 8 cycles; ADDI x0,x0,7 leaves dbg_rdata(0)=0.
- x1=-1, x2=1; run BLT x1,x2,+8 → pc advances by 8. Run BLTU x1,x2,+8 → pc advances by 4. Repeat for BEQ/BNE/BGE/BGEU, both taken and not taken.
- Word 0xFFFFFFFF at pc=0 → halted=1 at edge 2, pc_out stays 0, regs unchanged, stays halted for 20 cycles; then pulse reset → halted=0, pc=0.
- Taken BEQ x0,x0,+6 → halted=1, pc unchanged. BEQ x0,x0,-4 at pc=0 → pc=FFFFFFFC, fetch aliases to the top imem word.
- Assert flash on an EXEC cycle of ADDI x5 → x5 not written, pc=RESET_PC. Assert reset and flash together → regfile cleared, reset behaviour wins.
